// File: rtl/mem_channel_arbiter_if.sv
// Consumer-side and memory-side handshake buses of mem_channel_arbiter.
// slave is the arbiter's view; master is the view of the consumers plus memory.
interface mem_channel_arbiter_if #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2
);
    logic [NUM_CONSUMERS-1:0]                consumer_read_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_read_address;
    logic [NUM_CONSUMERS-1:0]                consumer_read_ready;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_read_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_valid;
    logic [NUM_CONSUMERS-1:0][ADDR_BITS-1:0] consumer_write_address;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] consumer_write_data;
    logic [NUM_CONSUMERS-1:0]                consumer_write_ready;
    logic [NUM_CHANNELS-1:0]                 mem_read_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address;
    logic [NUM_CHANNELS-1:0]                 mem_read_ready;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_valid;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_write_address;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_write_data;
    logic [NUM_CHANNELS-1:0]                 mem_write_ready;

    modport slave (
        input  consumer_read_valid, consumer_read_address,
        input  consumer_write_valid, consumer_write_address, consumer_write_data,
        input  mem_read_ready, mem_read_data, mem_write_ready,
        output consumer_read_ready, consumer_read_data, consumer_write_ready,
        output mem_read_valid, mem_read_address,
        output mem_write_valid, mem_write_address, mem_write_data
    );

    modport master (
        output consumer_read_valid, consumer_read_address,
        output consumer_write_valid, consumer_write_address, consumer_write_data,
        output mem_read_ready, mem_read_data, mem_write_ready,
        input  consumer_read_ready, consumer_read_data, consumer_write_ready,
        input  mem_read_valid, mem_read_address,
        input  mem_write_valid, mem_write_address, mem_write_data
    );
endinterface

// File: rtl/mem_channel_arbiter.sv
// N-consumer to M-channel memory arbiter: per-channel request/relay FSMs sharing
// one round-robin pointer; all outputs registered.
module mem_channel_arbiter #(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4,
    parameter int NUM_CHANNELS  = 2,
    parameter int WRITE_ENABLE  = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    mem_channel_arbiter_if.slave    bus,
    output logic [NUM_CHANNELS-1:0] channel_busy,
    output logic                    all_idle
);
    localparam int OW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;
    localparam logic [OW:0] NC = NUM_CONSUMERS[OW:0];

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_READ_WAIT   = 3'd1;
    localparam logic [2:0] S_WRITE_WAIT  = 3'd2;
    localparam logic [2:0] S_READ_RELAY  = 3'd3;
    localparam logic [2:0] S_WRITE_RELAY = 3'd4;

    logic [NUM_CHANNELS-1:0][2:0]            state_q, state_d;
    logic [NUM_CHANNELS-1:0][OW-1:0]         owner_q, owner_d;
    logic [NUM_CHANNELS-1:0]                 mrv_q, mrv_d, mwv_q, mwv_d;
    logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mra_q, mra_d, mwa_q, mwa_d;
    logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mwd_q, mwd_d;
    logic [NUM_CONSUMERS-1:0]                served_q, served_d;
    logic [NUM_CONSUMERS-1:0]                rrdy_q, rrdy_d, wrdy_q, wrdy_d;
    logic [NUM_CONSUMERS-1:0][DATA_BITS-1:0] rdata_q, rdata_d;
    logic [OW-1:0]                           rr_q, rr_d;
    logic [NUM_CHANNELS-1:0]                 busy_q, busy_d;
    logic                                    idle_q, idle_d;

    logic [NUM_CONSUMERS-1:0] taken;
    logic [OW:0]              scan, nxt;
    logic [OW-1:0]            idx, last;
    logic                     found, any_grant;

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        mrv_d    = mrv_q;
        mra_d    = mra_q;
        mwv_d    = mwv_q;
        mwa_d    = mwa_q;
        mwd_d    = mwd_q;
        served_d = served_q;
        rrdy_d   = rrdy_q;
        wrdy_d   = wrdy_q;
        rdata_d  = rdata_q;
        rr_d     = rr_q;
        taken    = served_q;
        scan     = '0;
        nxt      = '0;
        idx      = '0;
        last     = '0;
        found    = 1'b0;
        any_grant = 1'b0;
        // Channels claim in index order; taken keeps a consumer from being granted twice.
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            found = 1'b0;
            case (state_q[ch])
                S_IDLE: begin
                    for (int k = 0; k < NUM_CONSUMERS; k++) begin
                        scan = {1'b0, rr_q} + k[OW:0];
                        if (scan >= NC) scan = scan - NC;
                        idx = scan[OW-1:0];
                        if (!found && !taken[idx]) begin
                            if (bus.consumer_read_valid[idx]) begin
                                found       = 1'b1;
                                state_d[ch] = S_READ_WAIT;
                                mrv_d[ch]   = 1'b1;
                                mra_d[ch]   = bus.consumer_read_address[idx];
                            end else if (WRITE_ENABLE != 0 && bus.consumer_write_valid[idx]) begin
                                found       = 1'b1;
                                state_d[ch] = S_WRITE_WAIT;
                                mwv_d[ch]   = 1'b1;
                                mwa_d[ch]   = bus.consumer_write_address[idx];
                                mwd_d[ch]   = bus.consumer_write_data[idx];
                            end
                            if (found) begin
                                owner_d[ch]   = idx;
                                served_d[idx] = 1'b1;
                                taken[idx]    = 1'b1;
                                last          = idx;
                                any_grant     = 1'b1;
                            end
                        end
                    end
                end
                S_READ_WAIT: if (bus.mem_read_ready[ch]) begin
                    mrv_d[ch]              = 1'b0;
                    rdata_d[owner_q[ch]]   = bus.mem_read_data[ch];
                    rrdy_d[owner_q[ch]]    = 1'b1;
                    state_d[ch]            = S_READ_RELAY;
                end
                S_WRITE_WAIT: if (bus.mem_write_ready[ch]) begin
                    mwv_d[ch]              = 1'b0;
                    wrdy_d[owner_q[ch]]    = 1'b1;
                    state_d[ch]            = S_WRITE_RELAY;
                end
                S_READ_RELAY: if (!bus.consumer_read_valid[owner_q[ch]]) begin
                    rrdy_d[owner_q[ch]]    = 1'b0;
                    served_d[owner_q[ch]]  = 1'b0;
                    state_d[ch]            = S_IDLE;
                end
                S_WRITE_RELAY: if (!bus.consumer_write_valid[owner_q[ch]]) begin
                    wrdy_d[owner_q[ch]]    = 1'b0;
                    served_d[owner_q[ch]]  = 1'b0;
                    state_d[ch]            = S_IDLE;
                end
                default: state_d[ch] = S_IDLE;
            endcase
        end
        if (any_grant) begin
            nxt  = {1'b0, last} + {{OW{1'b0}}, 1'b1};
            rr_d = (nxt >= NC) ? '0 : nxt[OW-1:0];
        end
        for (int ch = 0; ch < NUM_CHANNELS; ch++) busy_d[ch] = (state_d[ch] != S_IDLE);
        idle_d = (busy_d == '0) && (served_d == '0);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= '0;
            owner_q  <= '0;
            mrv_q    <= '0;
            mra_q    <= '0;
            mwv_q    <= '0;
            mwa_q    <= '0;
            mwd_q    <= '0;
            served_q <= '0;
            rrdy_q   <= '0;
            wrdy_q   <= '0;
            rdata_q  <= '0;
            rr_q     <= '0;
            busy_q   <= '0;
            idle_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            mrv_q    <= mrv_d;
            mra_q    <= mra_d;
            mwv_q    <= mwv_d;
            mwa_q    <= mwa_d;
            mwd_q    <= mwd_d;
            served_q <= served_d;
            rrdy_q   <= rrdy_d;
            wrdy_q   <= wrdy_d;
            rdata_q  <= rdata_d;
            rr_q     <= rr_d;
            busy_q   <= busy_d;
            idle_q   <= idle_d;
        end
    end

    // Read-only instances tie every write output low.
    assign bus.consumer_read_ready  = rrdy_q;
    assign bus.consumer_read_data   = rdata_q;
    assign bus.consumer_write_ready = (WRITE_ENABLE != 0) ? wrdy_q : '0;
    assign bus.mem_read_valid       = mrv_q;
    assign bus.mem_read_address     = mra_q;
    assign bus.mem_write_valid      = (WRITE_ENABLE != 0) ? mwv_q : '0;
    assign bus.mem_write_address    = (WRITE_ENABLE != 0) ? mwa_q : '0;
    assign bus.mem_write_data       = (WRITE_ENABLE != 0) ? mwd_q : '0;
    assign channel_busy             = busy_q;
    assign all_idle                 = idle_q;
endmodule

// File: tb/tb_mem_channel_arbiter.sv
// Directed bench: a cycle table on a 2-channel instance plus hand sequences for
// reset, single read, write path, fairness and the read-only build.
module tb_mem_channel_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    mem_channel_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2)) bus0();
    mem_channel_arbiter_if #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1)) bus1();
    logic [1:0] busy0;
    logic       idle0;
    logic [0:0] busy1;
    logic       idle1;

    mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(2),
                          .WRITE_ENABLE(1)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0.slave), .channel_busy(busy0), .all_idle(idle0));
    mem_channel_arbiter #(.ADDR_BITS(8), .DATA_BITS(16), .NUM_CONSUMERS(4), .NUM_CHANNELS(1),
                          .WRITE_ENABLE(0)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1.slave), .channel_busy(busy1), .all_idle(idle1));

    typedef struct {
        logic [3:0]  rv, wv;
        logic [1:0]  mrr, mwr;
        logic [1:0]  e_mrv, e_mwv;
        logic [3:0]  e_rrdy, e_wrdy;
        logic [1:0]  e_busy;
        logic        e_idle;
        logic [15:0] e_mra, e_mwa;
    } vec_t;

    vec_t tbl [17];
    int   n_vec = 0;
    int   n_miss = 0;
    int   got [5];
    int   exp_order [5] = '{0, 1, 2, 3, 0};
    int   ng;
    logic prev;

    function automatic vec_t mk(logic [3:0] rv, logic [3:0] wv, logic [1:0] mrr, logic [1:0] mwr,
                                logic [1:0] e_mrv, logic [1:0] e_mwv, logic [3:0] e_rrdy,
                                logic [3:0] e_wrdy, logic [1:0] e_busy, logic e_idle,
                                logic [15:0] e_mra, logic [15:0] e_mwa);
        vec_t v;
        v.rv = rv; v.wv = wv; v.mrr = mrr; v.mwr = mwr;
        v.e_mrv = e_mrv; v.e_mwv = e_mwv; v.e_rrdy = e_rrdy; v.e_wrdy = e_wrdy;
        v.e_busy = e_busy; v.e_idle = e_idle; v.e_mra = e_mra; v.e_mwa = e_mwa;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        step();
    endtask

    initial begin
        bus0.consumer_read_valid = '0;  bus0.consumer_write_valid = '0;
        bus0.mem_read_ready = '0;       bus0.mem_write_ready = '0;
        bus0.mem_read_data = {16'hCAFE, 16'hBEEF};
        bus1.consumer_read_valid = '0;  bus1.consumer_write_valid = '0;
        bus1.mem_read_ready = '0;       bus1.mem_write_ready = '0;
        bus1.mem_read_data = {16'h1234};
        for (int c = 0; c < 4; c++) begin
            bus0.consumer_read_address[c]  = 8'h18 + 8'(c);
            bus0.consumer_write_address[c] = 8'h10 + 8'(c);
            bus0.consumer_write_data[c]    = 16'h0055 + 16'(c);
            bus1.consumer_read_address[c]  = 8'h18 + 8'(c);
            bus1.consumer_write_address[c] = 8'h10 + 8'(c);
            bus1.consumer_write_data[c]    = 16'h0055 + 16'(c);
        end

        tbl[0]  = mk(4'b1010, 4'b0000, 2'b00, 2'b00, 2'b11, 2'b00, 4'b0000, 4'b0000, 2'b11, 1'b0, 16'h1B19, 16'h0000);
        tbl[1]  = mk(4'b1010, 4'b0000, 2'b01, 2'b00, 2'b10, 2'b00, 4'b0010, 4'b0000, 2'b11, 1'b0, 16'h1B19, 16'h0000);
        tbl[2]  = mk(4'b1000, 4'b0000, 2'b10, 2'b00, 2'b00, 2'b00, 4'b1000, 4'b0000, 2'b10, 1'b0, 16'h1B19, 16'h0000);
        tbl[3]  = mk(4'b1001, 4'b0000, 2'b00, 2'b00, 2'b01, 2'b00, 4'b1000, 4'b0000, 2'b11, 1'b0, 16'h1B18, 16'h0000);
        tbl[4]  = mk(4'b0001, 4'b0000, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 4'b0000, 2'b01, 1'b0, 16'h1B18, 16'h0000);
        tbl[5]  = mk(4'b0001, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0001, 4'b0000, 2'b01, 1'b0, 16'h1B18, 16'h0000);
        tbl[6]  = mk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 2'b00, 1'b1, 16'h1B18, 16'h0000);
        tbl[7]  = mk(4'b0010, 4'b0010, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 4'b0000, 2'b01, 1'b0, 16'h1B19, 16'h0000);
        tbl[8]  = mk(4'b0010, 4'b0010, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0010, 4'b0000, 2'b01, 1'b0, 16'h1B19, 16'h0000);
        tbl[9]  = mk(4'b0000, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 2'b00, 1'b1, 16'h1B19, 16'h0000);
        tbl[10] = mk(4'b0000, 4'b0010, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0000, 4'b0000, 2'b01, 1'b0, 16'h1B19, 16'h0011);
        tbl[11] = mk(4'b0000, 4'b0010, 2'b00, 2'b01, 2'b00, 2'b00, 4'b0000, 4'b0010, 2'b01, 1'b0, 16'h1B19, 16'h0011);
        tbl[12] = mk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 2'b00, 1'b1, 16'h1B19, 16'h0011);
        tbl[13] = mk(4'b0100, 4'b0000, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 4'b0000, 2'b01, 1'b0, 16'h1B1A, 16'h0011);
        tbl[14] = mk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0000, 4'b0000, 2'b01, 1'b0, 16'h1B1A, 16'h0011);
        tbl[15] = mk(4'b0000, 4'b0000, 2'b01, 2'b00, 2'b00, 2'b00, 4'b0100, 4'b0000, 2'b01, 1'b0, 16'h1B1A, 16'h0011);
        tbl[16] = mk(4'b0000, 4'b0000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000, 4'b0000, 2'b00, 1'b1, 16'h1B1A, 16'h0011);

        // Outputs held at zero while reset is asserted, idle once released.
        #1;
        chk("rst idle", 64'(idle0), 64'h0);
        chk("rst mrv", 64'(bus0.mem_read_valid), 64'h0);
        step();
        reset = 1'b0;
        step();
        chk("post-rst busy", 64'(busy0), 64'h0);
        chk("post-rst idle", 64'(idle0), 64'h1);

        // Single read: consumer 2, address 0x1A, memory answers one cycle later.
        bus0.consumer_read_valid = 4'b0100;
        step();
        chk("rd1 mrv", 64'(bus0.mem_read_valid), 64'h1);
        chk("rd1 addr", 64'(bus0.mem_read_address[0]), 64'h1A);
        chk("rd1 rrdy early", 64'(bus0.consumer_read_ready), 64'h0);
        bus0.mem_read_ready = 2'b01;
        step();
        bus0.mem_read_ready = 2'b00;
        chk("rd1 mrv drop", 64'(bus0.mem_read_valid), 64'h0);
        chk("rd1 rrdy", 64'(bus0.consumer_read_ready), 64'h4);
        chk("rd1 data", 64'(bus0.consumer_read_data[2]), 64'hBEEF);
        step();
        chk("rd1 rrdy held", 64'(bus0.consumer_read_ready), 64'h4);
        bus0.consumer_read_valid = 4'b0000;
        step();
        chk("rd1 release", 64'(bus0.consumer_read_ready), 64'h0);
        chk("rd1 idle", 64'(idle0), 64'h1);
        chk("rd1 data kept", 64'(bus0.consumer_read_data[2]), 64'hBEEF);

        do_reset();
        for (int i = 0; i < 17; i++) begin
            bus0.consumer_read_valid  = tbl[i].rv;
            bus0.consumer_write_valid = tbl[i].wv;
            bus0.mem_read_ready       = tbl[i].mrr;
            bus0.mem_write_ready      = tbl[i].mwr;
            step();
            chk($sformatf("v%0d mrv", i),  64'(bus0.mem_read_valid),       64'(tbl[i].e_mrv));
            chk($sformatf("v%0d mwv", i),  64'(bus0.mem_write_valid),      64'(tbl[i].e_mwv));
            chk($sformatf("v%0d rrdy", i), 64'(bus0.consumer_read_ready),  64'(tbl[i].e_rrdy));
            chk($sformatf("v%0d wrdy", i), 64'(bus0.consumer_write_ready), 64'(tbl[i].e_wrdy));
            chk($sformatf("v%0d busy", i), 64'(busy0),                     64'(tbl[i].e_busy));
            chk($sformatf("v%0d idle", i), 64'(idle0),                     64'(tbl[i].e_idle));
            chk($sformatf("v%0d mra", i),  64'(bus0.mem_read_address),     64'(tbl[i].e_mra));
            chk($sformatf("v%0d mwa", i),  64'(bus0.mem_write_address),    64'(tbl[i].e_mwa));
        end
        chk("tbl rdata", 64'(bus0.consumer_read_data), 64'hCAFE_BEEF_BEEF_BEEF);

        // Reset in the middle of READ_WAIT clears everything at once.
        bus0.consumer_read_valid = 4'b0001;
        step();
        chk("mid mrv", 64'(bus0.mem_read_valid), 64'h1);
        #2 reset = 1'b1;
        #1;
        chk("mid-rst mrv", 64'(bus0.mem_read_valid), 64'h0);
        chk("mid-rst mra", 64'(bus0.mem_read_address), 64'h0);
        chk("mid-rst mwa", 64'(bus0.mem_write_address), 64'h0);
        chk("mid-rst rdata", 64'(bus0.consumer_read_data), 64'h0);
        chk("mid-rst busy", 64'(busy0), 64'h0);
        chk("mid-rst idle", 64'(idle0), 64'h0);
        bus0.consumer_read_valid = 4'b0000;
        step();
        reset = 1'b0;
        step();
        chk("after-rst busy", 64'(busy0), 64'h0);
        chk("after-rst idle", 64'(idle0), 64'h1);
        chk("after-rst mrv", 64'(bus0.mem_read_valid), 64'h0);

        // Write path with a slow memory acknowledge.
        do_reset();
        bus0.consumer_write_valid = 4'b0001;
        step();
        chk("wr mwv", 64'(bus0.mem_write_valid), 64'h1);
        for (int w = 0; w < 5; w++) begin
            step();
            chk($sformatf("wr%0d mwv", w), 64'(bus0.mem_write_valid), 64'h1);
            chk($sformatf("wr%0d mwa", w), 64'(bus0.mem_write_address), 64'h0010);
            chk($sformatf("wr%0d mwd", w), 64'(bus0.mem_write_data), 64'h0000_0055);
            chk($sformatf("wr%0d wrdy", w), 64'(bus0.consumer_write_ready), 64'h0);
        end
        bus0.mem_write_ready = 2'b01;
        step();
        bus0.mem_write_ready = 2'b00;
        chk("wr ack mwv", 64'(bus0.mem_write_valid), 64'h0);
        chk("wr ack wrdy", 64'(bus0.consumer_write_ready), 64'h1);
        bus0.consumer_write_valid = 4'b0000;
        step();
        chk("wr rel wrdy", 64'(bus0.consumer_write_ready), 64'h0);
        chk("wr rel idle", 64'(idle0), 64'h1);

        // Fairness on the single-channel instance: every consumer keeps asking.
        do_reset();
        for (int i = 0; i < 5; i++) got[i] = 99;
        ng = 0;
        prev = 1'b0;
        bus1.consumer_read_valid = 4'hF;
        for (int cyc = 0; cyc < 60 && ng < 5; cyc++) begin
            step();
            if (bus1.mem_read_valid[0] && !prev) begin
                got[ng] = int'(bus1.mem_read_address[0]) - 8'h18;
                ng++;
            end
            prev = bus1.mem_read_valid[0];
            bus1.mem_read_ready = bus1.mem_read_valid;
            bus1.consumer_read_valid = ~bus1.consumer_read_ready;
        end
        chk("fair count", 64'(ng), 64'd5);
        for (int i = 0; i < 5; i++)
            chk($sformatf("fair grant %0d", i), 64'(got[i]), 64'(exp_order[i]));
        bus1.consumer_read_valid = 4'h0;
        for (int i = 0; i < 3; i++) begin
            bus1.mem_read_ready = bus1.mem_read_valid;
            step();
        end
        bus1.mem_read_ready = 1'b0;

        // Read-only build ignores write requests entirely.
        do_reset();
        bus1.consumer_write_valid = 4'b0001;
        bus1.mem_write_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("ro%0d mwv", i), 64'(bus1.mem_write_valid), 64'h0);
            chk($sformatf("ro%0d mwa", i), 64'(bus1.mem_write_address), 64'h0);
            chk($sformatf("ro%0d mwd", i), 64'(bus1.mem_write_data), 64'h0);
            chk($sformatf("ro%0d wrdy", i), 64'(bus1.consumer_write_ready), 64'h0);
            chk($sformatf("ro%0d busy", i), 64'(busy1), 64'h0);
            chk($sformatf("ro%0d idle", i), 64'(idle1), 64'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/mem_channel_arbiter.md
# mem_channel_arbiter

Multi-channel memory arbiter between N consumers (LSUs or fetchers) and M memory channels, used for both the data and the program memory paths. Each channel runs its own request/response state machine: it holds a memory request until the memory acknowledges, then keeps the consumer's ready asserted until the consumer drops its valid. A shared round-robin pointer spreads grants fairly across consumers. Writes can be disabled for read-only use on the program-memory path.

## Interface
- ADDR_BITS, 8, address width
- DATA_BITS, 16, data width
- NUM_CONSUMERS, 4, number of requesters, ≥1
- NUM_CHANNELS, 2, number of memory channels, ≥1
- WRITE_ENABLE, 1, 1 = serve writes; 0 = read-only, all write ports ignored
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-high reset; one clock domain
- consumer_read_valid  in  [NUM_CONSUMERS]  read request, held until ready
- consumer_read_address  in  ADDR_BITS x NUM_CONSUMERS  read address
- consumer_read_ready  out  [NUM_CONSUMERS]  read data valid; held until the consumer drops valid
- consumer_read_data  out  DATA_BITS x NUM_CONSUMERS  returned read data
- consumer_write_valid  in  [NUM_CONSUMERS]  write request, held until ready
- consumer_write_address  in  ADDR_BITS x NUM_CONSUMERS  write address
- consumer_write_data  in  DATA_BITS x NUM_CONSUMERS  write data
- consumer_write_ready  out  [NUM_CONSUMERS]  write done; held until the consumer drops valid
- mem_read_valid  out  [NUM_CHANNELS]  channel read request
- mem_read_address  out  ADDR_BITS x NUM_CHANNELS  channel read address
- mem_read_ready  in  [NUM_CHANNELS]  memory read completion; data valid in the same cycle
- mem_read_data  in  DATA_BITS x NUM_CHANNELS  memory read data
- mem_write_valid  out  [NUM_CHANNELS]  channel write request
- mem_write_address  out  ADDR_BITS x NUM_CHANNELS  channel write address
- mem_write_data  out  DATA_BITS x NUM_CHANNELS  channel write data
- mem_write_ready  in  [NUM_CHANNELS]  memory write completion
- channel_busy  out  [NUM_CHANNELS]  channel state is not IDLE
- all_idle  out  1  every channel is IDLE and no consumer is being served

## Operation
- Per-channel FSM states: IDLE, READ_WAIT, WRITE_WAIT, READ_RELAY, WRITE_RELAY.
- Each channel registers an owner index (`$clog2` width, minimum 1 bit). A per-consumer `served` bit records that a consumer currently owns a channel.
- **IDLE:**
  - Scan consumers starting at `rr_ptr`, wrapping modulo NUM_CONSUMERS.
  - Pick the first consumer that is not served and has read_valid, or has write_valid when WRITE_ENABLE=1.
  - Read has priority over write for the same consumer.
  - On a read grant: mem_read_valid=1, latch the address, set the owner and `served`, go to READ_WAIT.
  - On a write grant: the same with the write ports, going to WRITE_WAIT.
- **Same-cycle grants:** channels claim in ascending index order. A consumer granted to a lower channel is excluded from higher channels in that cycle, so no consumer is ever granted twice.
- **rr_ptr:** becomes (last consumer granted this cycle + 1) mod NUM_CONSUMERS. It is unchanged if no grant occurred.
- **READ_WAIT:**
  - Hold mem_read_valid and the address until mem_read_ready=1.
  - On mem_read_ready=1: mem_read_valid=0, consumer_read_data[owner]=mem_read_data, consumer_read_ready[owner]=1, go to READ_RELAY.
- **WRITE_WAIT:**
  - Hold mem_write_valid, address and data until mem_write_ready=1.
  - On mem_write_ready=1: mem_write_valid=0, consumer_write_ready[owner]=1, go to WRITE_RELAY.
- **READ_RELAY / WRITE_RELAY:** when the owner's valid for that direction is 0: clear its ready, clear `served`, go to IDLE.
- **Valid dropped early:** a consumer that drops valid during a WAIT state violates protocol. The transaction still completes, and ready pulses for exactly one cycle.
- **Read and write both asserted:** the read is served first. The write is a separate later grant.
- **WRITE_ENABLE=0:** mem_write_valid, mem_write_address, mem_write_data and consumer_write_ready are tied to 0. write_valid is ignored and can never produce a grant.
- **NUM_CHANNELS > NUM_CONSUMERS:** the surplus channels simply stay IDLE.
- **consumer_read_data:** retains its last value after the relay ends.

## Timing
- **Reset:** asserting reset immediately forces every output to 0, including all data and address arrays. All FSMs go to IDLE; `rr_ptr`, the owners and all `served` bits clear.
- **Reset mid-transaction:** the in-flight request is dropped with no completion. Memory must tolerate a request that was withdrawn.
- **Grant latency:** a valid visible before edge E produces mem_*_valid after E (1 cycle).
- **Completion latency:** mem_*_ready sampled high at edge F produces consumer ready after F.
- **Release latency:** consumer valid sampled low at edge G drops ready after G; the channel is IDLE after G.
- **Regrant:** the earliest new grant on that channel is at edge G+1.
- **Minimum transaction:** 4 edges from consumer valid to channel free, given single-cycle memory and a consumer that drops valid immediately.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** assert reset mid-READ_WAIT -> all outputs 0 immediately; after release, channel_busy=0 and all_idle=1.
- **Single read:** consumer 2 reads 0x1A, memory returns 0xBEEF one cycle later -> mem_read_valid rises after 1 edge; consumer_read_ready[2]=1 with data 0xBEEF; ready clears one edge after valid drops.
- **Fairness:** NUM_CHANNELS=1, all 4 consumers hold read_valid continuously -> grant order 0,1,2,3,0; no consumer waits more than 3 transactions.
- **Parallel grants:** 2 channels, consumers 1 and 3 request together -> channel 0 takes 1 and channel 1 takes 3 in the same cycle; no double grant; rr_ptr=0 afterwards.
- **Write path:** consumer 0 writes 0x55 to 0x10; mem_write_ready is delayed 5 cycles -> address and data are stable throughout WRITE_WAIT; write_ready asserts after the ack. With WRITE_ENABLE=0 the same stimulus leaves every write output at 0.
- **Read and write together:** consumer 1 asserts read and write together -> read granted first; the write is granted only after the read relay completes.
